// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED pattern sequencer: FSM states,
// mode/rate encodings, divider reload value and per-mode starting pattern.
package led_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE
  } state_e;

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_SHIFT  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    RATE_1S      = 2'd0,
    RATE_HALF    = 2'd1,
    RATE_QUARTER = 2'd2,
    RATE_EIGHTH  = 2'd3
  } rate_e;

  localparam int unsigned MAX_LEDS = 64;

  // Terminal divider count: one step every clk_hz / 2^rate cycles.
  function automatic int unsigned delay_for_rate(input int unsigned clk_hz,
                                                 input logic [1:0]  rate);
    return (clk_hz >> rate) - 1;
  endfunction

  function automatic logic [MAX_LEDS-1:0] initial_pattern(input mode_e       mode,
                                                          input int unsigned n);
    logic [MAX_LEDS-1:0] p;
    p = '0;
    if (n != 0 && (mode == MODE_SHIFT || mode == MODE_BOUNCE)) p[0] = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Command/status bundle between the board top (master) and the sequencer (slave).
interface led_pattern_sequencer_if #(
  parameter int unsigned NUM_LEDS = 10
);
  logic                START;
  logic                STOP;
  logic [1:0]          RATE_SEL;
  logic [1:0]          MODE_SEL;
  logic [NUM_LEDS-1:0] LEDR;
  logic                BUSY;
  logic                TICK;

  modport master (output START, STOP, RATE_SEL, MODE_SEL,
                  input  LEDR, BUSY, TICK);
  modport slave  (input  START, STOP, RATE_SEL, MODE_SEL,
                  output LEDR, BUSY, TICK);
endinterface

// File: rtl/led_seq_tick_gen.sv
// Enable-gated step divider: period latched from rate_sel on load and at each wrap,
// so a mid-period rate change never lets the count overshoot.
module led_seq_tick_gen
  import led_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned DIV_WIDTH = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       load,
  input  logic [1:0] rate_sel,
  output logic       wrap,
  output logic       tick
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] delay_q;
  logic [DIV_WIDTH-1:0] delay_d;

  always_comb delay_d = DIV_WIDTH'(delay_for_rate(CLK_HZ, rate_sel));

  assign wrap = en && (cnt_q == delay_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      delay_q <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (load) begin
        cnt_q   <= '0;
        delay_q <= delay_d;
      end else if (clr) begin
        cnt_q <= '0;
      end else if (wrap) begin
        cnt_q   <= '0;
        delay_q <= delay_d;
        tick    <= 1'b1;
      end else if (en) begin
        cnt_q <= cnt_q + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// IDLE/RUN/PAUSE controller stepping an LED bank through four patterns.
// Define LED_SEQ_INPUT_SYNC_EN to accept START/STOP as asynchronous levels.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned NUM_LEDS  = 10,
  parameter int unsigned DIV_WIDTH = 26
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET_N,
  led_pattern_sequencer_if.slave bus
);

  // Asynchronous assert, two-flop synchronised release.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic start_cmd;
  logic stop_cmd;

`ifdef LED_SEQ_INPUT_SYNC_EN
  logic [2:0] start_sync_q;
  logic [2:0] stop_sync_q;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      start_sync_q <= '0;
      stop_sync_q  <= '0;
      start_cmd    <= 1'b0;
      stop_cmd     <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[1:0], bus.START};
      stop_sync_q  <= {stop_sync_q[1:0], bus.STOP};
      start_cmd    <= start_sync_q[1] & ~start_sync_q[2];
      stop_cmd     <= stop_sync_q[1] & ~stop_sync_q[2];
    end
  end
`else
  assign start_cmd = bus.START;
  assign stop_cmd  = bus.STOP;
`endif

  state_e state_q, state_d;
  logic   busy_q;
  logic   load_init, clr_leds, run_en, div_clr;
  logic   step, tick;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // STOP has priority over START in every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_cmd && !stop_cmd) state_d = S_RUN;
      S_RUN:   if (stop_cmd) state_d = S_PAUSE;
      S_PAUSE: if (stop_cmd) state_d = S_IDLE;
               else if (start_cmd) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_init = (state_q == S_IDLE) && start_cmd && !stop_cmd;
    clr_leds  = (state_q == S_PAUSE) && stop_cmd;
    run_en    = (state_q == S_RUN) && !stop_cmd;
    div_clr   = (state_q == S_IDLE);
  end

  led_seq_tick_gen #(
    .CLK_HZ   (CLK_HZ),
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick_gen (
    .clk     (CLOCK_50),
    .rst_n   (rst_n),
    .en      (run_en),
    .clr     (div_clr),
    .load    (load_init),
    .rate_sel(bus.RATE_SEL),
    .wrap    (step),
    .tick    (tick)
  );

  logic [NUM_LEDS-1:0] led_q, led_step, init_new;
  mode_e               mode_q, mode_in;
  logic                dir_up_q, dir_step;

  assign mode_in  = mode_e'(bus.MODE_SEL);
  assign init_new = NUM_LEDS'(initial_pattern(mode_in, NUM_LEDS));

  // Bounce flips direction as the lit bit lands on an end, so no end repeats.
  always_comb begin
    led_step = led_q;
    dir_step = dir_up_q;
    case (mode_q)
      MODE_BLINK: led_step = ~led_q;
      MODE_SHIFT: led_step = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
      MODE_BOUNCE: begin
        if (dir_up_q) begin
          led_step = led_q << 1;
          if (led_q[NUM_LEDS-2]) dir_step = 1'b0;
        end else begin
          led_step = led_q >> 1;
          if (led_q[1]) dir_step = 1'b1;
        end
      end
      MODE_COUNT: led_step = led_q + NUM_LEDS'(1);
      default:    led_step = led_q;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      led_q    <= '0;
      mode_q   <= MODE_BLINK;
      dir_up_q <= 1'b1;
    end else if (load_init || (step && mode_in != mode_q)) begin
      led_q    <= init_new;
      mode_q   <= mode_in;
      dir_up_q <= 1'b1;
    end else if (clr_leds) begin
      led_q <= '0;
    end else if (step) begin
      led_q    <= led_step;
      dir_up_q <= dir_step;
    end
  end

  assign bus.LEDR = led_q;
  assign bus.BUSY = busy_q;
  assign bus.TICK = tick;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench: a per-cycle reference model queues expected outputs,
// a negedge monitor pops and compares them against the sequencer.
module tb_led_pattern_sequencer;

  localparam int unsigned HZ = 80;
  localparam int unsigned N  = 10;

  typedef enum {M_IDLE, M_RUN, M_PAUSE} mstate_e;
  typedef struct packed {
    logic         busy;
    logic         tick;
    logic [N-1:0] leds;
  } exp_t;

  logic CLOCK_50 = 1'b0;
  logic RESET_N;
  always #5 CLOCK_50 = ~CLOCK_50;

  led_pattern_sequencer_if #(.NUM_LEDS(N)) bus ();

  led_pattern_sequencer #(
    .CLK_HZ   (HZ),
    .NUM_LEDS (N),
    .DIV_WIDTH(7)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  int   vectors    = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  // Pattern after k steps since the mode was (re)loaded.
  function automatic logic [N-1:0] pat(input logic [1:0] mode, input int unsigned k);
    int unsigned p;
    case (mode)
      2'd0:    pat = (k % 2 == 1) ? '1 : '0;
      2'd1:    pat = N'(1) << (k % N);
      2'd2: begin
        p = k % (2 * N - 2);
        if (p >= N) p = 2 * N - 2 - p;
        pat = N'(1) << p;
      end
      default: pat = N'(k % (1 << N));
    endcase
  endfunction

  function automatic int unsigned period(input logic [1:0] rate);
    return HZ / (1 << rate);
  endfunction

  mstate_e      m_state = M_IDLE;
  int unsigned  m_rem   = 0;
  int unsigned  m_k     = 0;
  logic [1:0]   m_mode  = 2'd0;
  logic [N-1:0] m_leds  = '0;

  always @(posedge CLOCK_50) begin
    logic m_tick;
    m_tick = 1'b0;
    if (!RESET_N) begin
      m_state = M_IDLE;
      m_leds  = '0;
    end else begin
      case (m_state)
        M_IDLE: if (bus.START && !bus.STOP) begin
          m_state = M_RUN;
          m_mode  = bus.MODE_SEL;
          m_k     = 0;
          m_leds  = pat(m_mode, m_k);
          m_rem   = period(bus.RATE_SEL);
        end
        M_RUN: if (bus.STOP) m_state = M_PAUSE;
        else begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_tick = 1'b1;
            m_rem  = period(bus.RATE_SEL);
            if (bus.MODE_SEL != m_mode) begin
              m_mode = bus.MODE_SEL;
              m_k    = 0;
            end else begin
              m_k = m_k + 1;
            end
            m_leds = pat(m_mode, m_k);
          end
        end
        default: if (bus.STOP) begin
          m_state = M_IDLE;
          m_leds  = '0;
        end else if (bus.START) m_state = M_RUN;
      endcase
    end
    exp_q.push_back('{busy: (m_state != M_IDLE), tick: m_tick, leds: m_leds});
  end

  always @(negedge CLOCK_50) begin
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty t=%0t: no expected entry queued", $time);
    end else begin
      e = exp_q.pop_front();
      if ({bus.BUSY, bus.TICK, bus.LEDR} !== e) begin
        miscompares++;
        $display("FAIL outputs t=%0t: got busy=%b tick=%b ledr=%h, want busy=%b tick=%b ledr=%h",
                 $time, bus.BUSY, bus.TICK, bus.LEDR, e.busy, e.tick, e.leds);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic pulse(input logic s, input logic p);
    bus.START = s;
    bus.STOP  = p;
    @(negedge CLOCK_50);
    bus.START = 1'b0;
    bus.STOP  = 1'b0;
  endtask

  initial begin
    RESET_N      = 1'b0;
    bus.START    = 1'b0;
    bus.STOP     = 1'b0;
    bus.RATE_SEL = 2'd3;
    bus.MODE_SEL = 2'd1;
    cyc(3);
    RESET_N = 1'b1;
    cyc(5);

    // Shift mode through a full wrap, then switch to bounce for 20+ ticks.
    pulse(1'b1, 1'b0);
    cyc(110);
    bus.MODE_SEL = 2'd2;
    cyc(215);

    // Pause mid-period, resume, then STOP twice back to idle.
    cyc(5);
    pulse(1'b0, 1'b1);
    cyc(30);
    pulse(1'b1, 1'b0);
    cyc(25);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    cyc(5);

    // Simultaneous START+STOP in IDLE and in RUN.
    pulse(1'b1, 1'b1);
    cyc(3);
    pulse(1'b1, 1'b0);
    cyc(7);
    pulse(1'b1, 1'b1);
    cyc(5);
    pulse(1'b0, 1'b1);
    cyc(3);

    // Rate change mid-period, then mode change to count and a full count wrap.
    bus.MODE_SEL = 2'd1;
    bus.RATE_SEL = 2'd3;
    pulse(1'b1, 1'b0);
    cyc(3);
    bus.RATE_SEL = 2'd0;
    cyc(200);
    bus.RATE_SEL = 2'd3;
    bus.MODE_SEL = 2'd3;
    cyc(10400);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);

    // Random commands and rate/mode changes.
    for (int i = 0; i < 3000; i++) begin
      bus.START = ($urandom_range(0, 39) == 0);
      bus.STOP  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 99) == 0) bus.RATE_SEL = 2'($urandom);
      if ($urandom_range(0, 149) == 0) bus.MODE_SEL = 2'($urandom);
      @(negedge CLOCK_50);
    end
    bus.START = 1'b0;
    bus.STOP  = 1'b0;
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);

    // Asynchronous reset while running with a lit LED.
    bus.MODE_SEL = 2'd1;
    bus.RATE_SEL = 2'd3;
    pulse(1'b1, 1'b0);
    cyc(4);
    #1 RESET_N = 1'b0;
    #1;
    vectors++;
    if ({bus.BUSY, bus.TICK, bus.LEDR} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got busy=%b tick=%b ledr=%h, want all zero",
               bus.BUSY, bus.TICK, bus.LEDR);
    end
    cyc(3);
    RESET_N = 1'b1;
    cyc(5);
    pulse(1'b1, 1'b0);
    cyc(30);

    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Run/pause/stop controller that sequences a bank of `NUM_LEDS` board LEDs through one of four display patterns. Steps occur at one of four selectable rates derived from `CLOCK_50`. It sits between the board-level top (keys, switches) and `LEDR`, replacing free-running blink dividers. It owns both the rate divider and the pattern state, and arbitrates start/stop commands against rate and mode changes.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency; base step period is 1 s.
- `NUM_LEDS`, 10, LED bank width (≥ 2).
- `DIV_WIDTH`, 26, divider counter width; must hold `CLK_HZ-1`.

Ports:
- `CLOCK_50`  in  1  system clock.
- `RESET_N`  in  1  reset, asynchronous, active-low.
- `START`  in  1  start/resume command strobe, active-high.
- `STOP`  in  1  pause/clear command strobe, active-high.
- `RATE_SEL`  in  2  step period: 0 = 1 s, 1 = 1/2 s, 2 = 1/4 s, 3 = 1/8 s.
- `MODE_SEL`  in  2  pattern: 0 = blink-all, 1 = shift-left wrap, 2 = bounce, 3 = binary count.
- `LEDR`  out  `NUM_LEDS`  pattern output.
- `BUSY`  out  1  high in RUN or PAUSE.
- `TICK`  out  1  one-cycle pulse on each pattern step.

## Operation
- **States:** IDLE, RUN, PAUSE. Reset → IDLE, `LEDR`=0, `BUSY`=0, `TICK`=0, divider=0.
- **IDLE:**
  - START → RUN.
  - Load the initial pattern of the current `MODE_SEL`.
  - Clear the divider.
- **RUN:**
  - STOP → PAUSE. `LEDR` and the divider are held.
  - START is ignored.
- **PAUSE:**
  - START → RUN, resuming with the divider phase preserved.
  - STOP → IDLE, with `LEDR` cleared.
- **Simultaneous START and STOP:** STOP wins in every state.
- **Divider:** counts only in RUN. At count == DELAY it wraps to 0, pulses `TICK` and steps the pattern. DELAY = `CLK_HZ/2^RATE_SEL - 1`, computed with integer division.
- **Rate changes:** `RATE_SEL` is latched into the active DELAY at entry to RUN from IDLE and at each wrap. A change mid-period takes effect on the following period, so the count never overshoots.
- **Mode changes:** `MODE_SEL` is latched at entry to RUN from IDLE and at each tick. If the latched mode differs at a tick, that tick loads the new mode's initial pattern instead of stepping.
- **Patterns (initial value → step rule):**
  - Blink-all: all 0 → bitwise invert.
  - Shift: bit0 set → rotate left; bit `NUM_LEDS-1` wraps to bit0.
  - Bounce: bit0 set, direction up → shift toward the end. Direction flips on reaching bit `NUM_LEDS-1` or bit0, so the sequence is 0,1,…,N-1,N-2,…,0,1 with no repeated end position.
  - Count: 0 → +1 modulo 2^`NUM_LEDS`; all-ones wraps to 0.

## Timing
- **Command edge n:**
  - State and `BUSY` update at edge n+1.
  - On IDLE→RUN, `LEDR` shows the initial pattern at n+1.
- **Step timing:**
  - The first `TICK` comes DELAY+1 cycles after entering RUN.
  - Subsequent ticks are every DELAY+1 RUN cycles.
  - `TICK` and the new `LEDR` value are registered and appear on the same edge.
- **Outputs:** all are registered; no combinational paths from input to output.
- **Reset:** asserting `RESET_N` mid-operation forces reset values immediately (asynchronous). Deassertion is synchronised internally with a two-flop release.

## Configuration
- **`LED_SEQ_INPUT_SYNC_EN` defined:**
  - `START` and `STOP` are treated as asynchronous levels, such as inverted KEY buttons.
  - Each passes through a two-flop synchroniser and a rising-edge detector.
  - This adds 3 cycles of command latency; a held level produces one command.
- **Undefined:** `START` and `STOP` are synchronous single-cycle strobes used directly. A held level re-issues the command every cycle.

## Structure
- **Package `led_seq_pkg`:**
  - State enum.
  - Mode and rate encodings.
  - Function `delay_for_rate(clk_hz, rate)`.
  - Function `initial_pattern(mode, n)`.
- **Sub-module `led_seq_tick_gen`:**
  - Enable-gated divider with clear and rate latch.
  - Outputs the `TICK` pulse.
  - Instantiated once.
- **Top:** the FSM and pattern register.

## Test plan
Bench runs with `CLK_HZ`=80, so DELAY = 79/39/19/9.

- **Start, shift mode:** reset, MODE=1, RATE=3, START pulse → `LEDR`=0x001 next cycle; `TICK` 10 cycles later with `LEDR`=0x002. After 10 ticks, `LEDR`=0x001 again (wrap).
- **Bounce:** MODE=2, RATE=3, run 20 ticks → bit positions 1…9,8…0,1; never two consecutive ticks at bit9.
- **Pause and stop:** STOP mid-period at count 5 → `LEDR` held and `BUSY`=1. START after 30 cycles → next `TICK` 5 cycles later. STOP twice → IDLE, `LEDR`=0, `BUSY`=0.
- **Simultaneous commands:** START and STOP in the same cycle while in IDLE → stays IDLE. In RUN → PAUSE.
- **Rate and mode change:**
  - RATE 3→0 at count 4 → current period ends at 10 cycles; the next period is 80.
  - MODE 1→3 mid-run → next tick `LEDR`=0x000, the following tick 0x001.
  - Count at 0x3FF ticks to 0x000.
- **Async reset:** `RESET_N` low mid-RUN → outputs 0 without a clock edge. With `LED_SEQ_INPUT_SYNC_EN`, START held for 50 cycles → exactly one start, `LEDR` valid 3 cycles late.
